// File: rtl/serial_async_tx_fifo.sv
// Asynchronous serial transmitter fed by a circular-buffer FIFO.
// Frames DATA_BITS-wide words LSB-first with optional parity and 1 or 2 stop bits.
module serial_async_tx_fifo #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          TxD,
  output logic                          TxD_busy
);

  localparam int CLKS_PER_BIT = (ClkFrequency + Baud / 2) / Baud;
  localparam int PtrW         = $clog2(FIFO_DEPTH);
  localparam int CountW       = PtrW + 1;
  localparam int TimerW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BitIdxW      = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : gBadBaud
    $error("serial_async_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("serial_async_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : gBadParity
    $error("serial_async_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("serial_async_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("serial_async_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {
    sIdle,
    sStart,
    sData,
    sParity,
    sStop
  } txState_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;
  logic [CountW-1:0]    count;
  logic                 wrAccept;
  logic                 pop;
  logic [DATA_BITS-1:0] headWord;

  assign full     = (count == CountW'(FIFO_DEPTH));
  assign wrAccept = wr_en && !full;
  assign headWord = mem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (wrAccept) wrPtr <= wrPtr + PtrW'(1);
      if (pop)      rdPtr <= rdPtr + PtrW'(1);
      case ({wrAccept, pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only read after a write has filled
  // it, and leaving it unreset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  txState_t             state;
  txState_t             nextState;
  logic [TimerW-1:0]    bitTimer;
  logic [BitIdxW-1:0]   bitIdx;
  logic                 stopIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityBit;
  logic                 bitTick;
  logic                 lastDataBit;
  logic                 lastStopBit;
  logic                 fifoNotEmpty;

  assign bitTick      = (bitTimer == TimerW'(CLKS_PER_BIT - 1));
  assign lastDataBit  = (bitIdx == BitIdxW'(DATA_BITS - 1));
  assign lastStopBit  = (stopIdx == 1'(STOP_BITS - 1));
  assign fifoNotEmpty = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= sIdle;
    else     state <= nextState;
  end

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      sIdle: begin
        if (fifoNotEmpty) begin
          pop       = 1'b1;
          nextState = sStart;
        end
      end
      sStart: begin
        if (bitTick) nextState = sData;
      end
      sData: begin
        if (bitTick && lastDataBit) nextState = (PARITY != 0) ? sParity : sStop;
      end
      sParity: begin
        if (bitTick) nextState = sStop;
      end
      sStop: begin
        // Chain straight into the next start bit when more words are waiting.
        if (bitTick && lastStopBit) begin
          if (fifoNotEmpty) begin
            pop       = 1'b1;
            nextState = sStart;
          end else begin
            nextState = sIdle;
          end
        end
      end
      default: nextState = sIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitTimer  <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
    end else if (pop) begin
      bitTimer  <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      shiftReg  <= headWord;
      parityBit <= (PARITY == 1) ? ~^headWord : ^headWord;
    end else if (state != sIdle) begin
      bitTimer <= bitTick ? '0 : bitTimer + TimerW'(1);
      if (bitTick && state == sData) begin
        shiftReg <= shiftReg >> 1;
        bitIdx   <= bitIdx + BitIdxW'(1);
      end
      if (bitTick && state == sStop) stopIdx <= ~stopIdx;
    end
  end

  always_comb begin
    TxD = 1'b1;
    case (state)
      sStart:  TxD = 1'b0;
      sData:   TxD = shiftReg[0];
      sParity: TxD = parityBit;
      default: TxD = 1'b1;
    endcase
  end

  assign TxD_busy   = (state != sIdle) || fifoNotEmpty;
  assign fifo_count = count;

endmodule

// File: tb/tb_serial_async_tx_fifo.sv
// Directed bench for serial_async_tx_fifo: five configurations share one clock;
// frames are decoded by sampling the line mid-bit and compared against hand-computed words.
module tb_serial_async_tx_fifo;

  localparam int Cpb    = 10;
  localparam int NumDut = 5;
  localparam int D8N1   = 0;
  localparam int D8E1   = 1;
  localparam int D8O1   = 2;
  localparam int D7E1   = 3;
  localparam int D8N2   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrEn   [NumDut];
  logic [7:0] wrData [NumDut];
  logic       full   [NumDut];
  logic [2:0] cnt    [NumDut];
  logic       ovf    [NumDut];
  logic       txd    [NumDut];
  logic       busy   [NumDut];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovfHits = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ovf[D8N1] === 1'b1) ovfHits <= ovfHits + 1;

  serial_async_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut8n1 (
    .clk(clk), .rst(rst), .wr_en(wrEn[D8N1]), .wr_data(wrData[D8N1]),
    .full(full[D8N1]), .fifo_count(cnt[D8N1]), .overflow(ovf[D8N1]),
    .TxD(txd[D8N1]), .TxD_busy(busy[D8N1]));

  serial_async_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DATA_BITS(8),
                         .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut8e1 (
    .clk(clk), .rst(rst), .wr_en(wrEn[D8E1]), .wr_data(wrData[D8E1]),
    .full(full[D8E1]), .fifo_count(cnt[D8E1]), .overflow(ovf[D8E1]),
    .TxD(txd[D8E1]), .TxD_busy(busy[D8E1]));

  serial_async_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DATA_BITS(8),
                         .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut8o1 (
    .clk(clk), .rst(rst), .wr_en(wrEn[D8O1]), .wr_data(wrData[D8O1]),
    .full(full[D8O1]), .fifo_count(cnt[D8O1]), .overflow(ovf[D8O1]),
    .TxD(txd[D8O1]), .TxD_busy(busy[D8O1]));

  serial_async_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DATA_BITS(7),
                         .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut7e1 (
    .clk(clk), .rst(rst), .wr_en(wrEn[D7E1]), .wr_data(wrData[D7E1][6:0]),
    .full(full[D7E1]), .fifo_count(cnt[D7E1]), .overflow(ovf[D7E1]),
    .TxD(txd[D7E1]), .TxD_busy(busy[D7E1]));

  serial_async_tx_fifo #(.ClkFrequency(1000000), .Baud(100000), .DATA_BITS(8),
                         .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut8n2 (
    .clk(clk), .rst(rst), .wr_en(wrEn[D8N2]), .wr_data(wrData[D8N2]),
    .full(full[D8N2]), .fifo_count(cnt[D8N2]), .overflow(ovf[D8N2]),
    .TxD(txd[D8N2]), .TxD_busy(busy[D8N2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeWord(input int sel, input logic [7:0] w);
    wrEn[sel]   = 1'b1;
    wrData[sel] = w;
    tick();
    wrEn[sel]   = 1'b0;
  endtask

  // Wait for a start bit, then sample each bit at its centre. Returns
  // positioned in the middle of the last stop bit (start + frameLen - 5).
  task automatic recvFrame(input int sel, input int nData, input int parOn, input int nStop,
                           output logic [7:0] data, output logic parBit, output int startCyc);
    int waited = 0;
    data     = '0;
    parBit   = 1'bx;
    startCyc = -1;
    while (txd[sel] !== 1'b0 && waited < 3000) begin
      tick();
      waited++;
    end
    if (txd[sel] !== 1'b0) begin
      check("start_timeout", 128'(txd[sel]), 128'(0));
    end else begin
      startCyc = cyc;
      tick(Cpb / 2);
      check("start_bit", 128'(txd[sel]), 128'(0));
      for (int k = 0; k < nData; k++) begin
        tick(Cpb);
        data[k] = txd[sel];
      end
      if (parOn != 0) begin
        tick(Cpb);
        parBit = txd[sel];
      end
      for (int s = 0; s < nStop; s++) begin
        tick(Cpb);
        check("stop_bit", 128'(txd[sel]), 128'(1));
      end
    end
  endtask

  // Called from the middle of the final stop bit: busy must hold for 4 more
  // cycles and drop on the 5th edge with nothing queued.
  task automatic checkFrameEnd(input int sel);
    tick(4);
    check("busy_before_end", 128'(busy[sel]), 128'(1));
    tick();
    check("busy_after_end", 128'(busy[sel]), 128'(0));
    check("txd_idle", 128'(txd[sel]), 128'(1));
  endtask

  logic [7:0]  ofWords   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  wrapWords [12];
  logic [7:0]  a5 = 8'hA5;
  logic [99:0] cap;
  logic [99:0] expWave;
  logic [7:0]  rxData;
  logic        rxPar;
  int          rxStart;
  int          firstStart;
  int          ovfBase;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NumDut; i++) begin
      wrEn[i]   = 1'b0;
      wrData[i] = '0;
    end
    tick(2);
    rst = 1'b0;
    tick();
    check("rst_txd",   128'(txd[D8N1]),  128'(1));
    check("rst_busy",  128'(busy[D8N1]), 128'(0));
    check("rst_count", 128'(cnt[D8N1]),  128'(0));

    // 8N1 single word 0xA5: exact 100-cycle line waveform after the pop edge.
    writeWord(D8N1, 8'hA5);
    check("e0_count", 128'(cnt[D8N1]),  128'(1));
    check("e0_busy",  128'(busy[D8N1]), 128'(1));
    check("e0_txd",   128'(txd[D8N1]),  128'(1));
    tick();
    check("e1_count", 128'(cnt[D8N1]), 128'(0));
    for (int i = 0; i < 100; i++) begin
      if (i < 10)      expWave[i] = 1'b0;
      else if (i < 90) expWave[i] = a5[(i - 10) / 10];
      else             expWave[i] = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      cap[i] = txd[D8N1];
      if (i == 99) check("a5_busy_last", 128'(busy[D8N1]), 128'(1));
      tick();
    end
    check("a5_waveform", 128'(cap), 128'(expWave));
    check("a5_busy_drop", 128'(busy[D8N1]), 128'(0));

    // Parity variants.
    writeWord(D8E1, 8'h55);
    recvFrame(D8E1, 8, 1, 1, rxData, rxPar, rxStart);
    check("8e1_data", 128'(rxData), 128'(8'h55));
    check("8e1_par",  128'(rxPar),  128'(0));
    checkFrameEnd(D8E1);

    writeWord(D8O1, 8'h55);
    recvFrame(D8O1, 8, 1, 1, rxData, rxPar, rxStart);
    check("8o1_data", 128'(rxData), 128'(8'h55));
    check("8o1_par",  128'(rxPar),  128'(1));
    checkFrameEnd(D8O1);

    writeWord(D7E1, 8'h01);
    recvFrame(D7E1, 7, 1, 1, rxData, rxPar, rxStart);
    check("7e1_data", 128'(rxData), 128'(8'h01));
    check("7e1_par",  128'(rxPar),  128'(1));
    checkFrameEnd(D7E1);

    // Two stop bits, back-to-back frames with no idle gap.
    wrEn[D8N2]   = 1'b1;
    wrData[D8N2] = 8'h00;
    tick();
    wrData[D8N2] = 8'hFF;
    tick();
    wrEn[D8N2]   = 1'b0;
    recvFrame(D8N2, 8, 0, 2, rxData, rxPar, firstStart);
    check("8n2_data0", 128'(rxData), 128'(8'h00));
    recvFrame(D8N2, 8, 0, 2, rxData, rxPar, rxStart);
    check("8n2_data1", 128'(rxData), 128'(8'hFF));
    check("8n2_spacing", 128'(rxStart - firstStart), 128'(110));
    checkFrameEnd(D8N2);

    // Full and overflow with depth 4: 6 consecutive writes, 5 accepted.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wrEn[D8N1]   = 1'b1;
          wrData[D8N1] = ofWords[i];
          tick();
          if (i == 4) begin
            check("of_full",      128'(full[D8N1]), 128'(1));
            check("of_count",     128'(cnt[D8N1]),  128'(4));
            check("of_ovf_early", 128'(ovf[D8N1]),  128'(0));
          end
          if (i == 5) begin
            check("of_ovf_pulse", 128'(ovf[D8N1]),  128'(1));
            check("of_count_kept", 128'(cnt[D8N1]), 128'(4));
          end
        end
        wrEn[D8N1] = 1'b0;
        tick();
        check("of_ovf_clear", 128'(ovf[D8N1]), 128'(0));
      end
      begin
        for (int j = 0; j < 5; j++) begin
          recvFrame(D8N1, 8, 0, 1, rxData, rxPar, rxStart);
          check("of_rx_word", 128'(rxData), 128'(ofWords[j]));
        end
      end
    join
    checkFrameEnd(D8N1);
    check("of_count_final", 128'(cnt[D8N1]), 128'(0));

    // Pointer wrap: 12 words with random gaps, writer never writes while full.
    for (int i = 0; i < 12; i++) wrapWords[i] = 8'($urandom);
    ovfBase = ovfHits;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int waited = 0;
          while (full[D8N1] && waited < 3000) begin
            tick();
            waited++;
          end
          if (full[D8N1]) check("wrap_full_timeout", 128'(full[D8N1]), 128'(0));
          wrEn[D8N1]   = 1'b1;
          wrData[D8N1] = wrapWords[i];
          tick();
          wrEn[D8N1]   = 1'b0;
          tick($urandom_range(0, 3));
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          recvFrame(D8N1, 8, 0, 1, rxData, rxPar, rxStart);
          check("wrap_rx_word", 128'(rxData), 128'(wrapWords[j]));
        end
      end
    join
    checkFrameEnd(D8N1);
    check("wrap_no_ovf", 128'(ovfHits - ovfBase), 128'(0));

    // Reset mid-frame with a full FIFO and a live overflow pulse.
    for (int i = 0; i < 6; i++) begin
      wrEn[D8N1]   = 1'b1;
      wrData[D8N1] = ofWords[i];
      tick();
    end
    wrEn[D8N1] = 1'b0;
    check("pre_rst_full", 128'(full[D8N1]), 128'(1));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("mid_rst_txd",   128'(txd[D8N1]),  128'(1));
    check("mid_rst_busy",  128'(busy[D8N1]), 128'(0));
    check("mid_rst_count", 128'(cnt[D8N1]),  128'(0));
    check("mid_rst_full",  128'(full[D8N1]), 128'(0));
    check("mid_rst_ovf",   128'(ovf[D8N1]),  128'(0));
    tick(20);
    check("post_rst_txd",  128'(txd[D8N1]),  128'(1));
    check("post_rst_busy", 128'(busy[D8N1]), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
